// File: rtl/shift_sequencer.sv
// Iterative 32-bit barrel shifter: one log2 level per clock, 6-cycle start-to-done latency.
// Optional macro SHIFT_SEQUENCER_SRA_EN enables arithmetic right shift with sign fill.
`timescale 1ns/1ps

module shift_sequencer #(
    parameter logic [5:0] OP_SLL = 6'b000000,
    parameter logic [5:0] OP_SRL = 6'b000010,
    parameter logic [5:0] OP_SRA = 6'b000011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    output logic        busy,
    output logic        done,
    output logic [31:0] dataOut
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

    state_t      state;
    logic [31:0] work;
    logic [4:0]  amt;
    logic [5:0]  op;
    logic [2:0]  level;
    logic        invalid;
`ifdef SHIFT_SEQUENCER_SRA_EN
    logic        signBit;
`endif

    logic        opSupported;
    logic [7:0]  amtExt;
    logic [4:0]  stepAmt;
    logic [31:0] shifted;

    always_comb begin
        opSupported = (Signal == OP_SLL) || (Signal == OP_SRL);
`ifdef SHIFT_SEQUENCER_SRA_EN
        opSupported = opSupported || (Signal == OP_SRA);
`endif
    end

    // Shift applied by the current level: distance 2^level when amt[level] is set.
    always_comb begin
        amtExt  = {3'b000, amt};
        stepAmt = 5'd1 << level;
        shifted = work;
        if (amtExt[level]) begin
            if (op == OP_SRL) begin
                shifted = work >> stepAmt;
`ifdef SHIFT_SEQUENCER_SRA_EN
            end else if (op == OP_SRA) begin
                shifted = (work >> stepAmt) | (~(32'hFFFF_FFFF >> stepAmt) & {32{signBit}});
`endif
            end else begin
                shifted = work << stepAmt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            dataOut <= 32'h0000_0000;
            work    <= 32'h0000_0000;
            amt     <= 5'd0;
            op      <= 6'd0;
            level   <= 3'd0;
            invalid <= 1'b0;
`ifdef SHIFT_SEQUENCER_SRA_EN
            signBit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                StIdle, StDone: begin
                    // flush wins over a simultaneous start
                    if (start && !flush) begin
                        work    <= dataA;
                        amt     <= dataB[4:0];
                        op      <= Signal;
                        level   <= 3'd0;
                        invalid <= (|dataB[31:5]) || !opSupported;
`ifdef SHIFT_SEQUENCER_SRA_EN
                        signBit <= dataA[31];
`endif
                        state   <= StShift;
                        busy    <= 1'b1;
                    end else begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                StShift: begin
                    if (flush) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        work  <= shifted;
                        level <= level + 3'd1;
                        if (level == 3'd4) begin
                            state   <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            dataOut <= invalid ? 32'h0000_0000 : shifted;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: driver pushes expected results, negedge monitor checks.
`timescale 1ns/1ps

module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] dataA = '0;
    logic [31:0] dataB = '0;
    logic [5:0]  Signal = '0;
    logic        busy;
    logic        done;
    logic [31:0] dataOut;

    shift_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .flush   (flush),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          busyLo = 1;
    int          busyHi = 0;
    int          freeAt = 0;
    logic [31:0] expOut = '0;
    logic        lastRst = 1'b1;
    logic        checking = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        lastRst <= !rst_n;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] refShift(input logic [31:0] a, input logic [31:0] b,
                                             input logic [5:0] sig);
        if (b > 32'd31) return 32'h0;
        if (sig == 6'b000000) return a << b[4:0];
        if (sig == 6'b000010) return a >> b[4:0];
`ifdef SHIFT_SEQUENCER_SRA_EN
        if (sig == 6'b000011) return $unsigned($signed(a) >>> b[4:0]);
`endif
        return 32'h0;
    endfunction

    // One clock of stimulus; afterwards the model learns what that cycle did.
    task automatic step(input logic st, input logic fl, input logic rs, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] sig);
        int t;
        start  = st;
        flush  = fl;
        rst_n  = ~rs;
        dataA  = a;
        dataB  = b;
        Signal = sig;
        @(posedge clk);
        #1;
        t = cyc - 1;
        if (rs) begin
            while (sb.size() > 0 && sb[$].cyc > t) void'(sb.pop_back());
            if (busyHi > t) busyHi = t;
            freeAt = t + 1;
        end else if (fl && t >= busyLo && t <= busyHi) begin
            while (sb.size() > 0 && sb[$].cyc > t) void'(sb.pop_back());
            busyHi = t;
            freeAt = t + 1;
        end else if (st && !fl && t >= freeAt) begin
            sb.push_back('{res: refShift(a, b, sig), cyc: t + 6});
            busyLo = t + 1;
            busyHi = t + 5;
            freeAt = t + 6;
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig);
        step(1'b1, 1'b0, 1'b0, a, b, sig);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'h0);
    endtask

    always @(negedge clk) begin
        logic expDone;
        if (checking) begin
            if (lastRst) expOut = 32'h0;
            expDone = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk("busy", {31'b0, busy}, {31'b0, (cyc >= busyLo && cyc <= busyHi)});
            chk("done", {31'b0, done}, {31'b0, expDone});
            if (expDone) begin
                expOut = sb[0].res;
                void'(sb.pop_front());
            end
            chk("dataOut", dataOut, expOut);
        end
    end

    initial begin
        logic [5:0] sigs [4];
        sigs[0] = 6'b000000;
        sigs[1] = 6'b000010;
        sigs[2] = 6'b000011;
        sigs[3] = 6'b111111;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 6'h0);
        checking = 1'b1;
        idle(2);

        issue(32'h8000_0000, 32'd31, 6'b000010);
        idle(6);
        issue(32'hFFFF_FFFF, 32'd32, 6'b000010);
        idle(6);
        issue(32'hF000_0000, 32'd4, 6'b000011);
        idle(6);
        issue(32'h1234_5678, 32'd3, 6'b111111);
        idle(6);
        issue(32'h0000_0001, 32'd4, 6'b000000);
        idle(6);

        // flush in T+3 leaves the previous result in place
        issue(32'hDEAD_BEEF, 32'd7, 6'b000010);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 6'h0);
        idle(4);

        // restart in T+2 is ignored; restart in the DONE cycle chains back-to-back
        issue(32'h0000_00F0, 32'd8, 6'b000000);
        idle(1);
        issue(32'hFFFF_0000, 32'd1, 6'b000010);
        idle(3);
        issue(32'hA5A5_A5A5, 32'd16, 6'b000010);
        idle(7);

        // flush together with start in the DONE cycle: nothing accepted
        issue(32'h0000_0003, 32'd2, 6'b000000);
        idle(5);
        step(1'b1, 1'b1, 1'b0, 32'h0000_0005, 32'd1, 6'b000000);
        idle(7);

        // reset mid-operation
        issue(32'h0F0F_0F0F, 32'd5, 6'b000000);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 6'h0);
        idle(8);

        for (int i = 0; i < 2000; i++) begin
            logic [31:0] b;
            b = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 31));
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 199) == 0), $urandom, b, sigs[$urandom_range(0, 3)]);
        end
        idle(10);

        chk("pendingResults", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter OP_SLL, default 6'b000000, function code selecting logical left shift.
REQ-002 Parameter OP_SRL, default 6'b000010, function code selecting logical right shift.
REQ-003 Parameter OP_SRA, default 6'b000011, function code selecting arithmetic right shift (honoured only per REQ-027).
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request to begin one shift operation.
REQ-007 flush  input  1  abort the operation in progress.
REQ-008 dataA  input  32  operand to be shifted; sampled only when start is accepted.
REQ-009 dataB  input  32  shift amount; sampled only when start is accepted.
REQ-010 Signal  input  6  function code; sampled only when start is accepted.
REQ-011 busy  output  1  high while an operation is in the SHIFT state.
REQ-012 done  output  1  single-cycle pulse marking dataOut as holding a new result.
REQ-013 dataOut  output  32  registered result; holds its value until the next completion.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE; busy=1 only in SHIFT; done=1 only in DONE.
REQ-015 start SHALL be accepted when the state is IDLE or DONE.
- On acceptance: capture dataA into the work register, dataB[4:0] into amt, and Signal into op.
- Set invalid = (dataB[31:5]!=0) OR (op not a supported code); clear the level counter to 0; go to SHIFT.
REQ-016 start SHALL be ignored while in SHIFT; captured operands SHALL NOT change.
REQ-017 In SHIFT, each edge applies level k (k = 0..4) of the shift, then increments k.
- If amt[k]=1: shift the work register by 2^k in the op direction; else leave it unchanged.
REQ-018 Vacated bit positions SHALL be filled with 0, except for SRA, which fills with the captured dataA[31].
REQ-019 After the edge applying level 4, the state SHALL go to DONE.
- On that same edge, dataOut SHALL load the work result, or 32'h00000000 if invalid.
REQ-020 Latency: start accepted in cycle T -> done=1 and the new dataOut visible in cycle T+6; busy=1 in cycles T+1..T+5.
REQ-021 Invalid operations SHALL take the same 6-cycle latency as valid ones.
REQ-022 DONE SHALL last one cycle, then go to IDLE, or to SHIFT if start is accepted in that cycle (back-to-back, 6-cycle throughput).
REQ-023 flush=1 in SHIFT SHALL return the FSM to IDLE on the next edge with no done pulse and dataOut unchanged; flush in IDLE/DONE SHALL have no effect.
REQ-024 flush and start together in the same cycle SHALL resolve as flush only: no operation accepted.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force state=IDLE, busy=0, done=0, dataOut=0, work=0, amt=0, op=0, k=0, invalid=0; reset has priority over flush and start.
REQ-026 Reset asserted mid-SHIFT SHALL abandon the operation; no done SHALL follow reset release until a new start completes.

Configuration
REQ-027 Macro SHIFT_SEQUENCER_SRA_EN:
- Defined: OP_SRA is a supported code with sign fill per REQ-018.
- Undefined: OP_SRA is treated as unsupported (invalid -> result 0), and no sign-fill logic SHALL be present.

Verification
REQ-028 SRL, dataA=32'h80000000, dataB=31, start in cycle T -> done=1 in T+6, dataOut=32'h00000001, busy high T+1..T+5.
REQ-029 SRL, dataA=32'hFFFFFFFF, dataB=32 -> done at T+6, dataOut=32'h00000000; SLL dataA=1, dataB=4 -> dataOut=32'h00000010.
REQ-030 SRA, dataA=32'hF0000000, dataB=4 -> dataOut=32'hFF000000 with SHIFT_SEQUENCER_SRA_EN; dataOut=32'h00000000 without it.
REQ-031 dataOut=32'h00000010 from a prior op; new SRL started, flush=1 in T+3 -> no done, dataOut stays 32'h00000010, busy=0 from T+4.
REQ-032 start pulsed again in T+2 with different operands -> ignored, first result at T+6.
- start in the DONE cycle T+6 -> second done at T+12 with the second operands' result.
REQ-033 rst_n=0 in T+3 of an operation -> from the next cycle busy=0, done=0, dataOut=0, and no done afterwards without a new start.
